// File: rtl/mon_prod_resp_pkg.sv
// Shared definitions for the Montgomery-product command interface:
// op_code values and responder state encoding.
package mon_prod_resp_pkg;

  localparam logic [1:0] OPXX   = 2'd0;
  localparam logic [1:0] OPXM   = 2'd1;
  localparam logic [1:0] OPX1   = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RDA  = 3'd1;
  localparam logic [2:0] ST_RDB  = 3'd2;
  localparam logic [2:0] ST_LDB  = 3'd3;
  localparam logic [2:0] ST_LOOP = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;
  localparam logic [2:0] ST_WR   = 3'd6;

endpackage

// File: rtl/mon_step.sv
// One radix-2 Montgomery iteration plus the S >= n compare/subtract used
// for the final correction.
module mon_step #(
  parameter int BITLEN = 256
) (
  input  logic [BITLEN+1:0] s,
  input  logic              a_bit,
  input  logic [BITLEN-1:0] b,
  input  logic [BITLEN-1:0] n,
  output logic [BITLEN+1:0] s_next,
  output logic [BITLEN+1:0] s_sub,
  output logic              s_ge_n
);

  logic [BITLEN+1:0] t_add;
  logic [BITLEN+1:0] t_red;

  // Adding the odd modulus to an odd sum makes it even, so the shift is exact.
  always_comb begin
    t_add  = s + (a_bit ? {2'b00, b} : '0);
    t_red  = t_add[0] ? (t_add + {2'b00, n}) : t_add;
    s_next = t_red >> 1;
  end

  assign s_ge_n = (s >= {2'b00, n});
  assign s_sub  = s - {2'b00, n};

endmodule

// File: rtl/mon_prod_resp.sv
// Montgomery-product responder: fetches A/B from the operand RAM, runs the
// bit-serial loop for mp_count iterations and writes P back to the X slot.
//
// state   | meaning
// IDLE    | wait for start rising edge with a legal op_code
// RDA     | read address of A on the RAM bus
// RDB     | capture A, present X address for B
// LDB     | capture B, clear S, load iteration counter
// LOOP    | one Montgomery iteration per cycle
// FIN     | conditional final subtraction of n
// WR      | write result, update P, raise stop
module mon_prod_resp
  import mon_prod_resp_pkg::*;
#(
  parameter int          BITLEN     = 256,
  parameter int          LOG_BITLEN = 8,
  parameter int          ABITS      = 8,
  parameter int          DBITS      = 256,
  parameter int unsigned ADDR_X     = 0,
  parameter int unsigned ADDR_M     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op_code,
  input  logic [BITLEN-1:0]     n,
  input  logic [LOG_BITLEN:0]   mp_count,
  output logic [ABITS-1:0]      rd_addr,
  input  logic [DBITS-1:0]      rd_data,
  output logic [DBITS-1:0]      wr_data,
  output logic [ABITS-1:0]      wr_addr,
  output logic                  wr_en,
  output logic                  stop,
  output logic [BITLEN-1:0]     P
);

  logic [2:0]          state;
  logic                start_q;
  logic [1:0]          op;
  logic [BITLEN-1:0]   a_sh;
  logic [BITLEN-1:0]   b_r;
  logic [BITLEN+1:0]   s;
  logic [LOG_BITLEN:0] cnt;
  logic [BITLEN+1:0]   s_step;
  logic [BITLEN+1:0]   s_sub;
  logic                s_ge_n;
  logic                accept;

  assign accept = (state == ST_IDLE) && start && !start_q && (op_code != OP_ILL);

  mon_step #(.BITLEN(BITLEN)) u_step (
    .s      (s),
    .a_bit  (a_sh[0]),
    .b      (b_r),
    .n      (n),
    .s_next (s_step),
    .s_sub  (s_sub),
    .s_ge_n (s_ge_n)
  );

  if (DBITS > BITLEN) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[DBITS-1:BITLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      op      <= OPXX;
      a_sh    <= '0;
      b_r     <= '0;
      s       <= '0;
      cnt     <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      stop    <= 1'b0;
      P       <= '0;
    end else begin
      start_q <= start;
      wr_en   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Address is driven from the accept edge so the synchronous RAM
          // returns A in time for the RDB capture.
          if (accept) begin
            stop    <= 1'b0;
            op      <= op_code;
            rd_addr <= (op_code == OPXM) ? ABITS'(ADDR_M) : ABITS'(ADDR_X);
            state   <= ST_RDA;
          end
        end
        ST_RDA: begin
          rd_addr <= ABITS'(ADDR_X);
          state   <= ST_RDB;
        end
        ST_RDB: begin
          a_sh  <= rd_data[BITLEN-1:0];
          state <= ST_LDB;
        end
        ST_LDB: begin
          b_r   <= (op == OPX1) ? BITLEN'(1) : rd_data[BITLEN-1:0];
          s     <= '0;
          cnt   <= mp_count;
          state <= (mp_count == '0) ? ST_FIN : ST_LOOP;
        end
        ST_LOOP: begin
          s     <= s_step;
          a_sh  <= a_sh >> 1;
          cnt   <= cnt - (LOG_BITLEN+1)'(1);
          if (cnt == (LOG_BITLEN+1)'(1)) state <= ST_FIN;
        end
        ST_FIN: begin
          if (s_ge_n) s <= s_sub;
          state <= ST_WR;
        end
        ST_WR: begin
          wr_en   <= 1'b1;
          wr_addr <= ABITS'(ADDR_X);
          wr_data <= DBITS'(s[BITLEN-1:0]);
          P       <= s[BITLEN-1:0];
          stop    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_prod_resp.sv
// Scoreboard bench for mon_prod_resp: driver pushes modular-arithmetic
// expectations, a monitor pops them on every write strobe.
module tb_mon_prod_resp;
  import mon_prod_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [7:0]  n = 8'd13;
  logic [3:0]  mp_count = 4'd4;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] wr_data;
  logic [7:0]  wr_addr;
  logic        wr_en;
  logic        stop;
  logic [7:0]  P;

  mon_prod_resp #(
    .BITLEN(8), .LOG_BITLEN(3), .ABITS(8), .DBITS(16), .ADDR_X(0), .ADDR_M(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code), .n(n),
    .mp_count(mp_count), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .stop(stop), .P(P)
  );

  always #5 clk = ~clk;

  // Operand RAM: synchronous read, DUT write port plus a bench preload port.
  logic [15:0] ram [0:255];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_waddr = 8'd0;
  logic [15:0] tb_wdata = 16'd0;
  always @(posedge clk) begin
    rd_data <= ram[rd_addr];
    if (wr_en) ram[wr_addr] <= wr_data;
    if (tb_we) ram[tb_waddr] <= tb_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int p; int cyc; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int exp_writes = 0;
  int mx = 0;
  int mm = 0;
  int nval = 13;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: P = (A mod 2^m) * B * (2^-m) mod n, with 2^-1 = (n+1)/2.
  function automatic int mont(input int a, input int b, input int nn, input int m);
    int ae;
    int inv;
    ae  = a % (1 << m);
    inv = 1;
    for (int k = 0; k < m; k++) inv = (inv * ((nn + 1) / 2)) % nn;
    return (((ae * b) % nn) * inv) % nn;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_data", int'(wr_data), e.p);
        chk("wr_addr", int'(wr_addr), 0);
        chk("P", int'(P), e.p);
        chk("stop_on_write", int'(stop), 1);
        chk("latency", cyc, e.cyc);
        writes++;
      end
    end
  end

  task automatic set_ram(input int addr, input int val);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_waddr = 8'(addr);
    tb_wdata = 16'(($urandom_range(0, 255) << 8) | val);
    @(negedge clk);
    tb_we    = 1'b0;
    if (addr == 0) mx = val; else mm = val;
  endtask

  task automatic issue(input logic [1:0] op, input int m, input bit glitch, output int e);
    int a;
    int b;
    int acc;
    a = (op == OPXM) ? mm : mx;
    b = (op == OPX1) ? 1 : mx;
    e = mont(a, b, nval, m);
    @(negedge clk);
    op_code  = op;
    mp_count = 4'(m);
    start    = 1'b1;
    acc      = cyc + 1;
    sb.push_back('{p: e, cyc: acc + m + 5});
    exp_writes++;
    @(negedge clk);
    chk("rd_addr_a", int'(rd_addr), (op == OPXM) ? 1 : 0);
    chk("stop_cleared", int'(stop), 0);
    @(negedge clk);
    chk("rd_addr_b", int'(rd_addr), 0);
    if (glitch) begin
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start   = 1'b1;
      op_code = OPXM;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(stop && sb.size() == 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("done_in_time", int'(k < 60), 1);
  endtask

  task automatic run(input logic [1:0] op, input int m, input bit glitch, output int e);
    issue(op, m, glitch, e);
    wait_done();
    mx    = e;
    start = 1'b0;
  endtask

  initial begin
    int e;
    int p_before;
    int s_before;
    logic [1:0] ops [3];
    ops[0] = OPXX; ops[1] = OPXM; ops[2] = OPX1;

    repeat (2) @(negedge clk);
    chk("rst_stop", int'(stop), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_P", int'(P), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    rst_n = 1'b1;

    set_ram(0, 5);
    set_ram(1, 7);
    run(OPXX, 4, 1'b0, e);
    chk("opxx_P_const", int'(P), 4);
    // start left high after completion must not retrigger
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;

    set_ram(0, 5);
    run(OPXM, 4, 1'b0, e);
    chk("opxm_P_const", int'(P), 3);

    set_ram(0, 5);
    run(OPX1, 4, 1'b0, e);
    chk("opx1_P_const", int'(P), 6);
    @(negedge clk);
    chk("ram_x_updated", int'(ram[0]), 6);

    // illegal op_code: no RAM activity, stop unchanged
    s_before = int'(stop);
    p_before = int'(rd_addr);
    @(negedge clk);
    op_code = OP_ILL;
    start   = 1'b1;
    repeat (8) @(negedge clk);
    chk("ill_rd_addr", int'(rd_addr), p_before);
    chk("ill_stop", int'(stop), s_before);
    start = 1'b0;

    set_ram(0, 5);
    run(OPXX, 4, 1'b1, e);
    chk("glitch_P_const", int'(P), 4);

    // reset in the middle of LOOP
    set_ram(0, 5);
    issue(OPXX, 4, 1'b0, e);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    exp_writes--;
    @(negedge clk);
    chk("midrst_stop", int'(stop), 0);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_P", int'(P), 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_ram_kept", int'(ram[0][7:0]), 5);
    run(OPXX, 4, 1'b0, e);
    chk("post_rst_P_const", int'(P), 4);

    run(OPXX, 0, 1'b0, e);
    chk("m0_P_const", int'(P), 0);

    // chained commands, each launched off the previous stop rise
    set_ram(0, 5);
    for (int i = 0; i < 3; i++) run(ops[i], 4, 1'b0, e);

    for (int i = 0; i < 20; i++) begin
      int m;
      m    = $urandom_range(2, 8);
      nval = 2 * $urandom_range(1, ((1 << m) - 2) / 2) + 1;
      n    = 8'(nval);
      set_ram(0, $urandom_range(0, nval - 1));
      set_ram(1, $urandom_range(0, nval - 1));
      run(ops[$urandom_range(0, 2)], m, 1'b0, e);
    end

    repeat (5) @(negedge clk);
    chk("write_count", writes, exp_writes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mon_prod_resp.md
Name: mon_prod_resp

Overview:
Responder end of the Montgomery-product command interface driven by the exponentiation controller. Accepts a start/op_code command, fetches operands from the shared operand RAM, and computes P = A·B·R⁻¹ mod n with a bit-serial radix-2 Montgomery loop, where R = 2^mp_count. It writes the result back to the X slot and raises stop; the controller detects the rising edge of stop.

Parameters:
BITLEN, 256, operand/modulus width
LOG_BITLEN, 8, log2(BITLEN); sizes the loop counter
ABITS, 8, operand RAM address width
DBITS, 256, operand RAM data width; must be >= BITLEN
ADDR_X, 0, RAM address of running value X_bar
ADDR_M, 1, RAM address of M_bar

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command request; accepted on rising edge only
op_code  in  2  0=OPXX (X·X), 1=OPXM (M·X), 2=OPX1 (X·1), 3=illegal
n  in  BITLEN  odd modulus, stable for the whole operation
mp_count  in  LOG_BITLEN+1  loop iterations (R = 2^mp_count)
rd_addr  out  ABITS  RAM read address; synchronous RAM, data valid next cycle
rd_data  in  DBITS  RAM read data; low BITLEN bits used
wr_data  out  DBITS  result, zero-extended
wr_addr  out  ABITS  always ADDR_X during a write
wr_en  out  1  one-cycle write strobe
stop  out  1  done level; rises on completion, falls when the next command is accepted
P  out  BITLEN  last result; held until the next completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE, stop=0, wr_en=0, P=0, rd_addr=0, wr_addr=0, wr_data=0, S=0, counter=0, start_q=0.
- start_q registers start every cycle. A command is accepted when state=IDLE and start && !start_q. op_code is sampled at acceptance.
- op_code=3 at acceptance: command ignored; stay IDLE; stop unchanged.
- A rising edge of start while not in IDLE is ignored. The current operation is not disturbed.
- States (one cycle each unless noted):
  - IDLE: on accept, clear stop, go to RDA.
  - RDA: rd_addr = (OPXM ? ADDR_M : ADDR_X); go to RDB.
  - RDB: capture A = rd_data[BITLEN-1:0]; rd_addr = ADDR_X; go to LDB.
  - LDB: capture B = (OPX1 ? 1 : rd_data[BITLEN-1:0]); S=0; i=0; go to LOOP, or to FIN if mp_count=0.
  - LOOP (mp_count cycles): T = S + (A[i] ? B : 0); if T[0] then T = T + n; S = T >> 1; i = i+1. Leave for FIN after iteration i = mp_count-1.
  - FIN: if S >= n then S = S - n; go to WR.
  - WR: wr_en=1, wr_addr=ADDR_X, wr_data=S; P<=S; stop<=1; go to IDLE.
- Width rule: S and T are BITLEN+2 bits. With A, B < n, S stays below 2n, so a single final subtraction suffices. P < n is guaranteed.
- Latency: stop rises mp_count+5 cycles after the accepting edge. The wr_en pulse and the P update occur on the same edge as the stop rise.
- OPXX reads ADDR_X twice; the second read is harmless and keeps the timing uniform.
- mp_count=0: P=0, written to ADDR_X, latency 5.
- start held high continuously: only one command is accepted. The controller must drop and re-raise start.
- Reset mid-operation: everything returns to reset values immediately; no write occurs.

Decomposition:
- Shared package holds the op_code constants (OPXX/OPXM/OPX1) and the state encoding. Both the controller and this block use them.
- One sub-module, mon_step: combinational one-iteration datapath (S, A bit, B, n → next S). It is reused by FIN for the conditional subtract (S_ge_n output).

Test Plan:
- BITLEN=8, LOG_BITLEN=3, n=13, mp_count=4, RAM[0]=5, start edge with OPXX -> stop rises 9 cycles later; P=4; one wr_en pulse with wr_addr=0, wr_data=4.
- Same setup, RAM[1]=7, OPXM -> P=3 (35·9 mod 13); rd_addr sequence 1, 0.
- Same setup, OPX1, RAM[0]=5 -> P=6 (5·9 mod 13); RAM[0] updated to 6.
- Start edge with op_code=3 -> no RAM read activity, no wr_en, stop unchanged. Second start edge during a LOOP -> ignored; result and latency unchanged.
- rst_n pulsed low mid-LOOP -> stop=0, wr_en never asserted, P=0. A fresh OPXX then completes normally with P=4.
- mp_count=0 -> P=0 after 5 cycles. Chained OPXX, OPXM, OPX1 driven by stop rising edges -> stop toggles low/high for each command and each result matches the reference model.
